iir_mac_seq: RTL and testbench

//  Sequential multiply-accumulate stage directly downstream of the sample-history shift register.

---
 rtl/iir_mac_seq.sv | 166 ++++++++++++++++
 tb/tb_iir_mac_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/iir_mac_seq.sv
// iir_mac_seq
// Sequential multiply-accumulate stage for a second-order IIR section.
// Computes y = a0*fk + a1*fk_1 + a2*fk_2 in signed Q(N).N fixed point.
// One multiplier is shared across three cycles. The result is saturated to
// W = 2N bits. A one-cycle done strobe and a sticky overflow flag go with it.
//
// Ports
//   clk        in   1   system clock, rising edge
//   reset_n    in   1   asynchronous active-low reset
//   start      in   1   request a computation; honoured only in IDLE
//   fk         in   W   current sample, signed Q(N).N
//   fk_1       in   W   sample k-1, signed
//   fk_2       in   W   sample k-2, signed
//   a0..a2     in   W   coefficients for fk, fk_1, fk_2, signed Q(N).N
//   y          out  W   saturated result; holds until the next result write
//   done       out  1   one-cycle pulse: y was written on the preceding edge
//   busy       out  1   high whenever the FSM is not in IDLE
//   ovf        out  1   sticky saturation flag for the current/last computation
//   state_dbg  out  3   current FSM state encoding (debug/observability)
//
// Handshake: start is sampled only while busy is low. Inputs are captured on
// the edge that accepts start and may change freely afterwards. done is high
// for exactly one cycle per accepted start. No start is queued while busy.
module iir_mac_seq #(
   parameter int N = 25
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic [2*N-1:0]      fk,
   input  logic [2*N-1:0]      fk_1,
   input  logic [2*N-1:0]      fk_2,
   input  logic [2*N-1:0]      a0,
   input  logic [2*N-1:0]      a1,
   input  logic [2*N-1:0]      a2,
   output logic [2*N-1:0]      y,
   output logic                done,
   output logic                busy,
   output logic                ovf,
   output logic [2:0]          state_dbg
);

   localparam int W  = 2 * N;
   localparam int PW = 2 * W;       // full product width
   localparam int SW = PW - N;      // width of the product after >>> N
   localparam int AW = W + 2;       // accumulator width, headroom for 3 terms

   localparam logic [W-1:0] MAX_W = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] MIN_W = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_MUL0 = 3'd1,
      S_MUL1 = 3'd2,
      S_MUL2 = 3'd3,
      S_SAT  = 3'd4,
      S_DONE = 3'd5
   } state_t;

   state_t state, state_nxt;

   logic signed [W-1:0]  fk_r, fk_1_r, fk_2_r, a0_r, a1_r, a2_r;
   logic signed [AW-1:0] acc;

   logic signed [W-1:0]  mul_x, mul_a;
   logic signed [PW-1:0] prod;
   logic signed [SW-1:0] scaled;
   logic                 term_fits;
   logic [W-1:0]         term;
   logic                 acc_fits;
   logic [W-1:0]         acc_sat;

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_MUL0;
         S_MUL0:  state_nxt = S_MUL1;
         S_MUL1:  state_nxt = S_MUL2;
         S_MUL2:  state_nxt = S_SAT;
         S_SAT:   state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---------------- output decode ----------------
   always_comb begin
      busy      = (state != S_IDLE);
      done      = (state == S_DONE);
      state_dbg = state;
   end

   // ---------------- shared multiplier ----------------
   // The operand pair is chosen by the state in which its term is accumulated.
   always_comb begin
      mul_x = fk_r;
      mul_a = a0_r;
      case (state)
         S_MUL1: begin mul_x = fk_1_r; mul_a = a1_r; end
         S_MUL2: begin mul_x = fk_2_r; mul_a = a2_r; end
         default: ;
      endcase
   end

   assign prod = mul_x * mul_a;

   // Dropping the N low bits of a signed value is an arithmetic shift.
   // It truncates toward minus infinity.
   assign scaled = prod[PW-1:N];

   // The term fits in W signed bits when every bit above W-1 equals the sign bit.
   assign term_fits = (&scaled[SW-1:W-1]) | ~(|scaled[SW-1:W-1]);
   assign term      = term_fits ? scaled[W-1:0]
                               : (scaled[SW-1] ? MIN_W : MAX_W);

   assign acc_fits = (&acc[AW-1:W-1]) | ~(|acc[AW-1:W-1]);
   assign acc_sat  = acc_fits ? acc[W-1:0]
                              : (acc[AW-1] ? MIN_W : MAX_W);

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fk_r   <= '0;
         fk_1_r <= '0;
         fk_2_r <= '0;
         a0_r   <= '0;
         a1_r   <= '0;
         a2_r   <= '0;
         acc    <= '0;
         y      <= '0;
         ovf    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  fk_r   <= fk;
                  fk_1_r <= fk_1;
                  fk_2_r <= fk_2;
                  a0_r   <= a0;
                  a1_r   <= a1;
                  a2_r   <= a2;
                  acc    <= '0;
                  ovf    <= 1'b0;
               end
            end
            S_MUL0, S_MUL1, S_MUL2: begin
               acc <= acc + {{(AW-W){term[W-1]}}, term};
               if (!term_fits) ovf <= 1'b1;
            end
            S_SAT: begin
               y <= acc_sat;
               if (!acc_fits) ovf <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_iir_mac_seq.sv
// tb_iir_mac_seq
// Directed bench for iir_mac_seq (N = 25, 1.0 = 2^25). Expected values are
// worked out by hand. Stimulus is driven #1 after a rising edge or on the
// falling edge. Outputs are sampled #1 after the rising edge.
module tb_iir_mac_seq;

   localparam int N = 25;
   localparam int W = 2 * N;

   localparam logic [W-1:0] ONE    = 50'd33554432;           // 1.0
   localparam logic [W-1:0] HALF   = 50'd16777216;           // 0.5
   localparam logic [W-1:0] QUART  = 50'd8388608;            // 0.25
   localparam logic [W-1:0] TWO    = 50'd67108864;           // 2.0
   localparam logic [W-1:0] M_ONE  = 50'h3_FFFF_FE00_0000;   // -1.0
   localparam logic [W-1:0] RAW_M1 = 50'h3_FFFF_FFFF_FFFF;   // -1 raw
   localparam logic [W-1:0] BIG    = 50'h1_0000_0000_0000;   // 2^48 raw
   localparam logic [W-1:0] M_BIG  = 50'h3_0000_0000_0000;   // -2^48 raw
   localparam logic [W-1:0] MAX_W  = 50'h1_FFFF_FFFF_FFFF;   // 2^49-1
   localparam logic [W-1:0] MIN_W  = 50'h2_0000_0000_0000;   // -2^49

   logic          clk;
   logic          reset_n;
   logic          start;
   logic [W-1:0]  fk, fk_1, fk_2, a0, a1, a2;
   logic [W-1:0]  y;
   logic          done, busy, ovf;
   logic [2:0]    state_dbg;

   int checks   = 0;
   int failures = 0;

   iir_mac_seq #(.N(N)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .fk        (fk),
      .fk_1      (fk_1),
      .fk_2      (fk_2),
      .a0        (a0),
      .a1        (a1),
      .a2        (a2),
      .y         (y),
      .done      (done),
      .busy      (busy),
      .ovf       (ovf),
      .state_dbg (state_dbg)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic [W-1:0] v_fk, input logic [W-1:0] v_fk_1,
                         input logic [W-1:0] v_fk_2, input logic [W-1:0] v_a0,
                         input logic [W-1:0] v_a1, input logic [W-1:0] v_a2);
      fk = v_fk; fk_1 = v_fk_1; fk_2 = v_fk_2;
      a0 = v_a0; a1 = v_a1; a2 = v_a2;
   endtask

   // Raise start for one edge (E0); returns at E0+1.
   task automatic launch();
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Full transaction with timing checks around the done strobe.
   task automatic run_and_check(input string tag, input logic [W-1:0] exp_y,
                                input logic exp_ovf);
      launch();
      check({tag, "_busy"}, 64'(busy), 64'(1'b1));
      repeat (3) @(posedge clk);
      #1 check({tag, "_done_early"}, 64'(done), 64'(1'b0));
      @(posedge clk);
      #1;
      check({tag, "_done"}, 64'(done), 64'(1'b1));
      check({tag, "_y"},    64'(y),    64'(exp_y));
      check({tag, "_ovf"},  64'(ovf),  64'(exp_ovf));
      @(posedge clk);
      #1;
      check({tag, "_done_off"}, 64'(done), 64'(1'b0));
      check({tag, "_idle"},     64'(busy), 64'(1'b0));
   endtask

   // ---------------- directed sequence ----------------
   initial begin : main
      logic seen;
      int   gap;

      reset_n = 1'b0;
      start   = 1'b0;
      set_in('0, '0, '0, '0, '0, '0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_y",     64'(y),         64'd0);
      check("rst_done",  64'(done),      64'd0);
      check("rst_busy",  64'(busy),      64'd0);
      check("rst_ovf",   64'(ovf),       64'd0);
      check("rst_state", 64'(state_dbg), 64'd0);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk);

      // 1.0 * 0.5
      set_in(ONE, '0, '0, HALF, '0, '0);
      run_and_check("single", HALF, 1'b0);

      // 1*0.25 + 2*0.25 + (-1)*0.5 = 0.25
      set_in(ONE, TWO, M_ONE, QUART, QUART, HALF);
      run_and_check("three", QUART, 1'b0);

      // -1 raw * 0.5 floors to -1 raw
      set_in(RAW_M1, '0, '0, HALF, '0, '0);
      run_and_check("negtrunc", RAW_M1, 1'b0);

      // Two huge terms each clamp to MAX; their sum clamps again.
      set_in(BIG, BIG, '0, BIG, BIG, '0);
      run_and_check("sat_pos", MAX_W, 1'b1);
      @(posedge clk);
      #1 check("ovf_held", 64'(ovf), 64'd1);

      set_in('0, '0, '0, '0, '0, '0);
      run_and_check("ovf_clear", '0, 1'b0);

      // A negative product too large clamps to MIN.
      set_in(M_BIG, '0, '0, BIG, '0, '0);
      run_and_check("sat_neg", MIN_W, 1'b1);

      // Load a non-zero y, then abort a computation during MUL1.
      set_in(ONE, '0, '0, HALF, '0, '0);
      run_and_check("pre_abort", HALF, 1'b0);
      launch();
      @(posedge clk);
      #1 reset_n = 1'b0;
      #1;
      check("abort_y",    64'(y),    64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_ovf",  64'(ovf),  64'd0);
      @(negedge clk) reset_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1 if (done) seen = 1'b1;
      end
      check("abort_no_done", 64'(seen), 64'd0);
      check("abort_y_held",  64'(y),    64'd0);

      // start during MUL2 and DONE is ignored; inputs change after capture.
      set_in(ONE, TWO, M_ONE, QUART, QUART, HALF);
      launch();
      set_in(BIG, BIG, BIG, BIG, BIG, BIG);
      @(posedge clk);
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check("ign_mul2_done", 64'(done), 64'd0);
      @(posedge clk);
      #1;
      check("ign_done", 64'(done), 64'd1);
      check("ign_y",    64'(y),    64'(QUART));
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check("ign_idle0", 64'(busy), 64'd0);
      @(posedge clk);
      #1 check("ign_idle1", 64'(busy), 64'd0);

      // start held high: back-to-back results every 6 cycles.
      set_in(ONE, '0, '0, HALF, '0, '0);
      @(negedge clk) start = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk);
         #1 if (done) seen = 1'b1;
      end
      check("b2b_first", 64'(seen), 64'd1);
      check("b2b_y1",    64'(y),    64'(HALF));
      seen = 1'b0;
      gap  = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk);
         gap++;
         #1 if (done) seen = 1'b1;
      end
      check("b2b_second", 64'(seen), 64'd1);
      check("b2b_gap",    64'(gap),  64'd6);
      check("b2b_y2",     64'(y),    64'(HALF));
      @(negedge clk) start = 1'b0;
      repeat (2) @(posedge clk);
      #1 check("b2b_stop", 64'(busy), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin : watchdog
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
